// File: rtl/instruction_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : instruction_sequencer
//  Description : Fetch/decode/execute sequencer for the Hydra core; fetches
//                two-word instructions, owns the PC and gates commits.
//  Revision    : 1.0
// ============================================================================
module instruction_sequencer #(
    parameter int ADDR_W   = 10,
    parameter int RESET_PC = 0
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [15:0]       imem_data,
    input  logic              halt,
    input  logic              button_pause,
    input  logic              jump,
    input  logic              branch_cond,
    input  logic [ADDR_W-1:0] jump_target,
    input  logic              io_button,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [15:0]       inst1,
    output logic [15:0]       inst2,
    output logic              exec_en,
    output logic [ADDR_W-1:0] pc,
    output logic              io_waiting,
    output logic              halted,
    output logic [15:0]       retired
);

    localparam logic [ADDR_W-1:0] c_reset_pc = ADDR_W'(RESET_PC);

    typedef enum logic [2:0] {
        S_FETCH1 = 3'd0,
        S_FETCH2 = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_IOWAIT = 3'd4,
        S_HALT   = 3'd5
    } state_t;

    state_t            r_state_q,      w_state_d;
    logic [ADDR_W-1:0] r_pc_q,         w_pc_d;
    logic [15:0]       r_inst1_q,      w_inst1_d;
    logic [15:0]       r_inst2_q,      w_inst2_d;
    logic [15:0]       r_retired_q,    w_retired_d;
    logic              r_io_waiting_q, w_io_waiting_d;
    logic              r_halted_q,     w_halted_d;

    logic              w_commit;
    logic [ADDR_W-1:0] w_pc_plus1;
    logic [ADDR_W-1:0] w_pc_plus2;

    assign w_pc_plus1 = r_pc_q + ADDR_W'(1);
    assign w_pc_plus2 = r_pc_q + ADDR_W'(2);

    always_comb begin
        w_state_d   = r_state_q;
        w_pc_d      = r_pc_q;
        w_inst1_d   = r_inst1_q;
        w_inst2_d   = r_inst2_q;
        w_retired_d = r_retired_q;
        w_commit    = 1'b0;

        case (r_state_q)
            S_FETCH1: w_state_d = S_FETCH2;
            S_FETCH2: begin
                w_inst1_d = imem_data;
                w_state_d = S_DECODE;
            end
            S_DECODE: begin
                w_inst2_d = imem_data;
                w_state_d = S_EXEC;
            end
            S_EXEC: begin
                if (halt) begin
                    w_state_d = S_HALT;
                end else if (button_pause) begin
                    w_state_d = S_IOWAIT;
                end else begin
                    w_commit = 1'b1;
                end
            end
            S_IOWAIT: w_commit = io_button;
            S_HALT:   w_state_d = S_HALT;
            default:  w_state_d = S_FETCH1;
        endcase

        if (w_commit) begin
            w_state_d   = S_FETCH1;
            w_pc_d      = (jump && branch_cond) ? jump_target : w_pc_plus2;
            w_retired_d = r_retired_q + 16'd1;
        end

        w_io_waiting_d = (w_state_d == S_IOWAIT);
        w_halted_d     = (w_state_d == S_HALT);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state_q      <= S_FETCH1;
            r_pc_q         <= c_reset_pc;
            r_inst1_q      <= 16'd0;
            r_inst2_q      <= 16'd0;
            r_retired_q    <= 16'd0;
            r_io_waiting_q <= 1'b0;
            r_halted_q     <= 1'b0;
        end else begin
            r_state_q      <= w_state_d;
            r_pc_q         <= w_pc_d;
            r_inst1_q      <= w_inst1_d;
            r_inst2_q      <= w_inst2_d;
            r_retired_q    <= w_retired_d;
            r_io_waiting_q <= w_io_waiting_d;
            r_halted_q     <= w_halted_d;
        end
    end

    // The second word sits at pc+1 and wraps past the top of the address space.
    assign imem_addr  = (r_state_q == S_FETCH2) ? w_pc_plus1 : r_pc_q;
    assign exec_en    = w_commit & ~reset;
    assign inst1      = r_inst1_q;
    assign inst2      = r_inst2_q;
    assign pc         = r_pc_q;
    assign io_waiting = r_io_waiting_q;
    assign halted     = r_halted_q;
    assign retired    = r_retired_q;

endmodule
`default_nettype wire

// File: tb/tb_instruction_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_instruction_sequencer
//  Description : Random-program bench for instruction_sequencer with an
//                instruction-level reference model and a commit scoreboard.
//  Revision    : 1.0
// ============================================================================
module tb_instruction_sequencer;

    localparam int AW     = 4;
    localparam int RST_PC = 0;

    typedef struct {
        bit          is_halt;
        bit          paused;
        logic [3:0]  pc;
        logic [15:0] i1;
        logic [15:0] i2;
        logic [15:0] ret;
    } rec_t;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic          io_button = 1'b0;
    logic [15:0]   imem_data;
    logic          halt, button_pause, jump, branch_cond;
    logic [AW-1:0] jump_target, imem_addr, pc;
    logic [15:0]   inst1, inst2, retired;
    logic          exec_en, io_waiting, halted;

    logic [15:0]   rom [16];
    rec_t          sb [$];
    int            vectors = 0;
    int            miscompares = 0;
    int            pops = 0;

    instruction_sequencer #(.ADDR_W(AW), .RESET_PC(RST_PC)) dut (
        .clock        (clock),
        .reset        (reset),
        .imem_data    (imem_data),
        .halt         (halt),
        .button_pause (button_pause),
        .jump         (jump),
        .branch_cond  (branch_cond),
        .jump_target  (jump_target),
        .io_button    (io_button),
        .imem_addr    (imem_addr),
        .inst1        (inst1),
        .inst2        (inst2),
        .exec_en      (exec_en),
        .pc           (pc),
        .io_waiting   (io_waiting),
        .halted       (halted),
        .retired      (retired)
    );

    always #5 clock = ~clock;

    always @(posedge clock) imem_data <= rom[imem_addr];

    // Toy decoder: flag bits in the first word, jump target in the second.
    assign halt         = inst1[15];
    assign button_pause = inst1[14];
    assign jump         = inst1[13];
    assign branch_cond  = inst1[12];
    assign jump_target  = inst2[AW-1:0];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    function automatic logic [15:0] gen_word(input bit plain);
        logic [15:0] w;
        w = 16'($urandom);
        w[15] = !plain && ($urandom_range(0, 39) == 0);
        w[14] = !plain && ($urandom_range(0, 4) == 0);
        w[13] = !plain && ($urandom_range(0, 2) == 0);
        return w;
    endfunction

    // Walk the program instruction by instruction from the reset PC.
    task automatic build_model(output int first_pause);
        int          p;
        int          r;
        rec_t        rc;
        first_pause = -1;
        p = RST_PC;
        r = 0;
        for (int i = 0; i < 40; i++) begin
            rc.pc      = 4'(p);
            rc.i1      = rom[p];
            rc.i2      = rom[(p + 1) % 16];
            rc.ret     = 16'(r);
            rc.is_halt = rc.i1[15];
            rc.paused  = rc.i1[14];
            sb.push_back(rc);
            if (rc.is_halt) break;
            if (rc.paused && first_pause < 0) first_pause = i;
            r = (r + 1) % 65536;
            if (rc.i1[13] && rc.i1[12]) p = int'(rc.i2[3:0]);
            else                        p = (p + 2) % 16;
        end
    endtask

    task automatic check_reset_state();
        check("rst_pc",         32'(pc),         32'(RST_PC));
        check("rst_imem_addr",  32'(imem_addr),  32'(RST_PC));
        check("rst_inst1",      32'(inst1),      32'd0);
        check("rst_inst2",      32'(inst2),      32'd0);
        check("rst_retired",    32'(retired),    32'd0);
        check("rst_exec_en",    32'(exec_en),    32'd0);
        check("rst_io_waiting", 32'(io_waiting), 32'd0);
        check("rst_halted",     32'(halted),     32'd0);
    endtask

    task automatic run_episode(input int ep);
        int fp, k, budget, wait_c, halt_c, start_pops;
        bit hold, prev_btn;
        for (int a = 0; a < 16; a++) rom[a] = gen_word(ep == 0);

        // Reset lands on whatever state the previous episode left (often IOWAIT).
        reset = 1'b1; io_button = 1'b1;
        @(posedge clock); #1;
        check("rst_entry_exec_en", 32'(exec_en), 32'd0);
        check("rst_entry_inst1",   32'(inst1),   32'd0);
        check("rst_entry_retired", 32'(retired), 32'd0);
        @(posedge clock); #1;
        reset = 1'b0; io_button = 1'b0;
        @(posedge clock); #1;
        // Now in FETCH2: reset here must discard the fetch.
        reset = 1'b1; io_button = 1'b1;
        @(posedge clock); #1;
        check_reset_state();
        reset = 1'b0; io_button = 1'b0;
        build_model(fp);

        hold       = (ep % 3 == 2) && (fp >= 0);
        k          = (ep == 0) ? 3 : $urandom_range(4, 30);
        start_pops = pops;
        wait_c     = 0;
        halt_c     = 0;
        prev_btn   = 1'b0;
        budget     = 3000;
        while (1) begin
            @(posedge clock); #1;
            if (halted) halt_c++;
            if (hold && io_waiting) wait_c++;
            if (halt_c >= 15 || wait_c >= 10 || (!hold && pops - start_pops >= k)) break;
            budget--;
            if (budget == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL episode_timeout ep=%0d: got %0d commits expected %0d", ep, pops - start_pops, k);
                break;
            end
            if (prev_btn || (hold && io_waiting)) io_button = 1'b0;
            else if (io_waiting)                  io_button = ($urandom_range(0, 3) == 0);
            else                                  io_button = ($urandom_range(0, 7) == 0);
            prev_btn = io_button;
        end
    endtask

    // Monitor: per-cycle comparison against the head of the scoreboard.
    initial begin
        int          cnt;
        rec_t        h;
        logic        e_exec, e_wait, e_halt;
        logic [3:0]  e_addr;
        cnt = 0;
        forever begin
            @(negedge clock);
            if (reset) begin
                cnt = 0;
                sb.delete();
                check("exec_en_in_reset", 32'(exec_en), 32'd0);
            end else begin
                cnt++;
                if (sb.size() == 0) begin
                    check("exec_en_idle", 32'(exec_en), 32'd0);
                end else begin
                    h      = sb[0];
                    e_addr = (cnt == 2) ? h.pc + 4'd1 : h.pc;
                    if (h.is_halt)     e_exec = 1'b0;
                    else if (h.paused) e_exec = (cnt >= 5) && io_button;
                    else               e_exec = (cnt == 4);
                    e_wait = !h.is_halt && h.paused && (cnt >= 5);
                    e_halt = h.is_halt && (cnt >= 5);
                    check("pc",         32'(pc),         32'(h.pc));
                    check("imem_addr",  32'(imem_addr),  32'(e_addr));
                    check("retired",    32'(retired),    32'(h.ret));
                    check("exec_en",    32'(exec_en),    32'(e_exec));
                    check("io_waiting", 32'(io_waiting), 32'(e_wait));
                    check("halted",     32'(halted),     32'(e_halt));
                    if (cnt >= 4) begin
                        check("inst1", 32'(inst1), 32'(h.i1));
                        check("inst2", 32'(inst2), 32'(h.i2));
                    end
                    if (exec_en && !h.is_halt) begin
                        void'(sb.pop_front());
                        pops++;
                        cnt = 0;
                    end
                end
            end
        end
    end

    initial begin
        for (int a = 0; a < 16; a++) rom[a] = 16'd0;
        for (int ep = 0; ep < 15; ep++) run_episode(ep);
        reset = 1'b1;
        repeat (2) @(posedge clock);
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
